// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for a single-clock FIFO built around a
// dual-pointer RAM with a two-register read path (address register, data register).
module fifo_ctrl #(
   parameter int AWIDTH           = 4,
   parameter int ALMOST_FULL_LVL  = 12,
   parameter int ALMOST_EMPTY_LVL = 2
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              wrreq_i,
   input  logic              rdreq_i,
   output logic              wren_o,
   output logic [AWIDTH-1:0] wrpntr_o,
   output logic [AWIDTH-1:0] rdpntr_o,
   output logic              rdval_o,
   output logic [AWIDTH:0]   usedw_o,
   output logic              full_o,
   output logic              empty_o,
   output logic              almost_full_o,
   output logic              almost_empty_o,
   output logic              ovf_o,
   output logic              udf_o
);

   localparam logic [AWIDTH:0] DEPTH  = (AWIDTH+1)'(2**AWIDTH);
   localparam logic [AWIDTH:0] AF_LVL = (AWIDTH+1)'(ALMOST_FULL_LVL);
   localparam logic [AWIDTH:0] AE_LVL = (AWIDTH+1)'(ALMOST_EMPTY_LVL);

   logic              wr_acc;
   logic              rd_acc;
   logic [AWIDTH:0]   usedw_nxt;
   logic              vld_p0;
   logic              vld_p1;

   // Accepts are gated by the registered flags, so a full FIFO never takes a
   // write in the same cycle a read frees a slot (and vice versa when empty).
   assign wr_acc = wrreq_i & ~full_o  & ~srst_i;
   assign rd_acc = rdreq_i & ~empty_o & ~srst_i;
   assign wren_o = wr_acc;

   always_comb begin
      usedw_nxt = usedw_o + {{AWIDTH{1'b0}}, wr_acc} - {{AWIDTH{1'b0}}, rd_acc};
   end

   // Stage p0/p1: rd_acc follows the RAM address register and then its data register.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         wrpntr_o       <= '0;
         rdpntr_o       <= '0;
         usedw_o        <= '0;
         full_o         <= 1'b0;
         empty_o        <= 1'b1;
         almost_full_o  <= 1'b0;
         almost_empty_o <= 1'b1;
         ovf_o          <= 1'b0;
         udf_o          <= 1'b0;
         vld_p0         <= 1'b0;
         vld_p1         <= 1'b0;
      end else begin
         if (wr_acc) wrpntr_o <= wrpntr_o + AWIDTH'(1);
         if (rd_acc) rdpntr_o <= rdpntr_o + AWIDTH'(1);
         usedw_o        <= usedw_nxt;
         full_o         <= (usedw_nxt == DEPTH);
         empty_o        <= (usedw_nxt == '0);
         almost_full_o  <= (usedw_nxt >= AF_LVL);
         almost_empty_o <= (usedw_nxt <  AE_LVL);
         ovf_o          <= wrreq_i & full_o;
         udf_o          <= rdreq_i & empty_o;
         vld_p0         <= rd_acc;
         vld_p1         <= vld_p0;
      end
   end

   assign rdval_o = vld_p1;

endmodule
